// File: rtl/usb_txn_ctrl.sv
// USB host transaction sequencer: token, optional DATA0, handshake/receive wait, ACK.
// Optional `TXN_RETRY_EN enables MAX_RETRY attempts; without it the first failure ends the transaction.
module usb_txn_ctrl #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 8
) (
  input  logic        clk,
  input  logic        rst_L,
  input  logic        txn_start,
  input  logic        txn_in,
  input  logic [6:0]  txn_addr,
  input  logic [3:0]  txn_endp,
  input  logic [63:0] txn_wdata,
  output logic        busy,
  output logic        txn_done,
  output logic        txn_ok,
  output logic [63:0] txn_rdata,
  output logic [3:0]  out_pid,
  output logic [6:0]  out_addr,
  output logic [3:0]  out_endp,
  output logic [63:0] out_data,
  output logic        out_pktready,
  input  logic        out_sent,
  output logic        writing,
  input  logic        in_pktready,
  input  logic        in_ack,
  input  logic        in_nak,
  input  logic        in_error,
  input  logic [63:0] in_data
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_ACK   = 4'b0010;

  typedef enum logic [3:0] {
    IDLE, TOK, TOK_W, DAT, DAT_W, HS_W, RX_W, ACK_TX, ACK_W, DONE
  } state_t;

  state_t      r_state, w_next;
  logic        r_dir_in;
  logic [6:0]  r_addr;
  logic [3:0]  r_endp;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic [7:0]  r_tmo;
  logic        r_ok;
  logic        w_ok_next;
  logic        w_fail;
  logic        w_capture;
  logic        w_timeout;
  logic        w_last_try;
  logic        w_wait_state;

`ifdef TXN_RETRY_EN
  logic [3:0]  r_retry;
  assign w_last_try = (r_retry == 4'(MAX_RETRY - 1));
`else
  assign w_last_try = 1'b1;
`endif

  assign w_timeout    = (r_tmo == 8'(TIMEOUT));
  assign w_wait_state = (r_state == HS_W) || (r_state == RX_W);

  always_comb begin
    w_next    = r_state;
    w_ok_next = r_ok;
    w_fail    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE:   if (txn_start) begin
                w_next    = TOK;
                w_ok_next = 1'b0;
              end
      TOK:    w_next = TOK_W;
      TOK_W:  if (out_sent) w_next = r_dir_in ? RX_W : DAT;
      DAT:    w_next = DAT_W;
      DAT_W:  if (out_sent) w_next = HS_W;
      HS_W:   if (in_ack) begin
                w_next    = DONE;
                w_ok_next = 1'b1;
              end else if (in_nak || in_error || w_timeout) begin
                w_fail = 1'b1;
              end
      // An errored packet is never captured, even with in_pktready set.
      RX_W:   if (in_error) begin
                w_fail = 1'b1;
              end else if (in_pktready) begin
                w_capture = 1'b1;
                w_next    = ACK_TX;
              end else if (in_nak || w_timeout) begin
                w_fail = 1'b1;
              end
      ACK_TX: w_next = ACK_W;
      ACK_W:  if (out_sent) begin
                w_next    = DONE;
                w_ok_next = 1'b1;
              end
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (w_fail) begin
      if (w_last_try) begin
        w_next    = DONE;
        w_ok_next = 1'b0;
      end else begin
        w_next = TOK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      r_state  <= IDLE;
      r_dir_in <= 1'b0;
      r_addr   <= '0;
      r_endp   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_tmo    <= '0;
      r_ok     <= 1'b0;
`ifdef TXN_RETRY_EN
      r_retry  <= '0;
`endif
    end else begin
      r_state <= w_next;
      r_ok    <= w_ok_next;
      if (r_state == IDLE && txn_start) begin
        r_dir_in <= txn_in;
        r_addr   <= txn_addr;
        r_endp   <= txn_endp;
        r_wdata  <= txn_wdata;
      end
      if (w_capture) r_rdata <= in_data;
      if ((w_next == HS_W || w_next == RX_W) && (w_next != r_state)) r_tmo <= '0;
      else if (w_wait_state) r_tmo <= r_tmo + 8'd1;
`ifdef TXN_RETRY_EN
      if (r_state == IDLE && txn_start) r_retry <= '0;
      else if (w_fail && !w_last_try)   r_retry <= r_retry + 4'd1;
`endif
    end
  end

  always_comb begin
    out_pid = 4'b0000;
    case (r_state)
      TOK, TOK_W:    out_pid = r_dir_in ? PID_IN : PID_OUT;
      DAT, DAT_W:    out_pid = PID_DATA0;
      ACK_TX, ACK_W: out_pid = PID_ACK;
      default:       out_pid = 4'b0000;
    endcase
  end

  assign busy         = (r_state != IDLE);
  assign txn_done     = (r_state == DONE);
  assign txn_ok       = (r_state == DONE) && r_ok;
  assign txn_rdata    = r_rdata;
  assign out_addr     = r_addr;
  assign out_endp     = r_endp;
  assign out_data     = r_wdata;
  assign out_pktready = (r_state == TOK) || (r_state == DAT) || (r_state == ACK_TX);
  assign writing      = (r_state == TOK) || (r_state == TOK_W) || (r_state == DAT) ||
                        (r_state == DAT_W) || (r_state == ACK_TX) || (r_state == ACK_W);

endmodule
